// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage 16-bit pipeline.
// Generates stall/flush controls, ALU forwarding selects and memory-wait diagnostics.
//
// state       | meaning
// ------------+---------------------------------------------------------
// RUN         | no hazard was seen on the previous cycle
// LOAD_BUBBLE | a load-use bubble was inserted on the previous cycle
// MEM_WAIT    | a data-memory access was waiting on the previous cycle
module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 4,
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1D,
    input  logic [ADDR_W-1:0] rs2D,
    input  logic              useRs1D,
    input  logic              useRs2D,
    input  logic [ADDR_W-1:0] destAddE,
    input  logic              RegWriteE,
    input  logic              MemToRegE,
    input  logic [ADDR_W-1:0] destAddM,
    input  logic              RegWriteM,
    input  logic [ADDR_W-1:0] destAddW,
    input  logic              RegWriteW,
    input  logic              branchTakenE,
    input  logic              memReqM,
    input  logic              memReadyM,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        fwdSel1E,
    output logic [1:0]        fwdSel2E,
    output logic              memTimeout,
    output logic [CNT_W-1:0]  stallCount,
    output logic [1:0]        stateOut
);

    localparam logic [1:0]  S_RUN  = 2'd0;
    localparam logic [1:0]  S_LB   = 2'd1;
    localparam logic [1:0]  S_MW   = 2'd2;
    localparam logic [16:0] LIMIT  = 17'(WAIT_LIMIT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              mem_wait;
    logic              load_use;
    logic [ADDR_W-1:0] rs1E;
    logic [ADDR_W-1:0] rs2E;
    logic              use1E;
    logic              use2E;
    logic [15:0]       wait_cnt;
    logic [16:0]       wait_inc;

    assign mem_wait = memReqM & ~memReadyM;
    assign load_use = RegWriteE & MemToRegE &
                      ((useRs1D & (rs1D == destAddE)) | (useRs2D & (rs2D == destAddE)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_RUN;
        if (mem_wait)                       state_nxt = S_MW;
        else if (load_use && !branchTakenE) state_nxt = S_LB;
    end

    // Controls are Mealy: they react to the hazard in the same cycle it is visible.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (reset) begin
            if (mem_wait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
            end else if (branchTakenE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end
        end
    end

    assign stateOut = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1E  <= '0;
            rs2E  <= '0;
            use1E <= 1'b0;
            use2E <= 1'b0;
        end else if (stallE) begin
            rs1E  <= rs1E;
            rs2E  <= rs2E;
            use1E <= use1E;
            use2E <= use2E;
        end else if (flushE) begin
            rs1E  <= '0;
            rs2E  <= '0;
            use1E <= 1'b0;
            use2E <= 1'b0;
        end else begin
            rs1E  <= rs1D;
            rs2E  <= rs2D;
            use1E <= useRs1D;
            use2E <= useRs2D;
        end
    end

    always_comb begin
        fwdSel1E = 2'b00;
        fwdSel2E = 2'b00;
        if (reset) begin
            if (use1E && RegWriteM && (destAddM == rs1E))      fwdSel1E = 2'b10;
            else if (use1E && RegWriteW && (destAddW == rs1E)) fwdSel1E = 2'b01;
            if (use2E && RegWriteM && (destAddM == rs2E))      fwdSel2E = 2'b10;
            else if (use2E && RegWriteW && (destAddW == rs2E)) fwdSel2E = 2'b01;
        end
    end

    // Every cycle the access is still waiting counts, including the one that enters MEM_WAIT;
    // the counter parks at the limit so it cannot wrap.
    assign wait_inc = {1'b0, wait_cnt} + 17'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt   <= '0;
            memTimeout <= 1'b0;
        end else if (mem_wait) begin
            if ({1'b0, wait_cnt} < LIMIT) wait_cnt <= wait_inc[15:0];
            if (wait_inc >= LIMIT)        memTimeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                        stallCount <= '0;
        else if (stallF && !(&stallCount)) stallCount <= stallCount + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_LIMIT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rs1D, rs2D, destAddE, destAddM, destAddW;
    logic       useRs1D, useRs2D, RegWriteE, MemToRegE, RegWriteM, RegWriteW;
    logic       branchTakenE, memReqM, memReadyM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, memTimeout;
    logic [1:0] fwdSel1E, fwdSel2E, stateOut;
    logic [15:0] stallCount;
    logic [5:0] ctl;

    int pass_cnt  = 0;
    int check_cnt = 0;

    assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ADDR_W(4), .WAIT_LIMIT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .useRs1D(useRs1D), .useRs2D(useRs2D),
        .destAddE(destAddE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .destAddM(destAddM), .RegWriteM(RegWriteM),
        .destAddW(destAddW), .RegWriteW(RegWriteW),
        .branchTakenE(branchTakenE), .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .fwdSel1E(fwdSel1E), .fwdSel2E(fwdSel2E),
        .memTimeout(memTimeout), .stallCount(stallCount), .stateOut(stateOut)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; useRs1D = 0; useRs2D = 0;
        destAddE = 0; RegWriteE = 0; MemToRegE = 0;
        destAddM = 0; RegWriteM = 0; destAddW = 0; RegWriteW = 0;
        branchTakenE = 0; memReqM = 0; memReadyM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        memReqM = 1; memReadyM = 0;
        #2;
        check_cnt++; if (ctl !== 6'b000000) $display("FAIL rst_ctl: got %b want 000000", ctl); else pass_cnt++;
        tick();
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL rst_state: got %0d want 0", stateOut); else pass_cnt++;
        check_cnt++; if (stallCount !== 16'd0) $display("FAIL rst_stallcount: got %0d want 0", stallCount); else pass_cnt++;
        check_cnt++; if (memTimeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", memTimeout); else pass_cnt++;
        check_cnt++; if (fwdSel1E !== 2'b00) $display("FAIL rst_fwd1: got %b want 00", fwdSel1E); else pass_cnt++;
        clear_inputs();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        RegWriteE = 1; MemToRegE = 1; destAddE = 3;
        rs1D = 3; useRs1D = 1;
        #1;
        check_cnt++; if (ctl !== 6'b110001) $display("FAIL lu_ctl: got %b want 110001", ctl); else pass_cnt++;
        tick();
        check_cnt++; if (stateOut !== 2'd1) $display("FAIL lu_state: got %0d want 1", stateOut); else pass_cnt++;
        RegWriteE = 0; MemToRegE = 0; destAddE = 0;
        destAddM = 3; RegWriteM = 1;
        #1;
        check_cnt++; if (ctl !== 6'b000000) $display("FAIL lu_nostall: got %b want 000000", ctl); else pass_cnt++;
        check_cnt++; if (fwdSel1E !== 2'b00) $display("FAIL lu_bubble_fwd: got %b want 00", fwdSel1E); else pass_cnt++;
        tick();
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL lu_state_run: got %0d want 0", stateOut); else pass_cnt++;
        RegWriteM = 0; destAddM = 0;
        destAddW = 3; RegWriteW = 1;
        #1;
        check_cnt++; if (fwdSel1E !== 2'b01) $display("FAIL lu_fwd_w: got %b want 01", fwdSel1E); else pass_cnt++;
        check_cnt++; if (stallCount !== 16'd1) $display("FAIL lu_stallcount: got %0d want 1", stallCount); else pass_cnt++;
    endtask

    task automatic test_forward();
        do_reset();
        rs1D = 5; useRs1D = 1;
        tick();
        destAddM = 5; RegWriteM = 1; destAddW = 5; RegWriteW = 1;
        #1;
        check_cnt++; if (fwdSel1E !== 2'b10) $display("FAIL fwd_m_prio: got %b want 10", fwdSel1E); else pass_cnt++;
        check_cnt++; if (fwdSel2E !== 2'b00) $display("FAIL fwd_rs2_unused: got %b want 00", fwdSel2E); else pass_cnt++;
        RegWriteM = 0;
        #1;
        check_cnt++; if (fwdSel1E !== 2'b01) $display("FAIL fwd_w: got %b want 01", fwdSel1E); else pass_cnt++;
        useRs1D = 0; rs2D = 7; useRs2D = 1;
        tick();
        RegWriteM = 1;
        #1;
        check_cnt++; if (fwdSel1E !== 2'b00) $display("FAIL fwd_nouse: got %b want 00", fwdSel1E); else pass_cnt++;
        destAddW = 7;
        #1;
        check_cnt++; if (fwdSel2E !== 2'b01) $display("FAIL fwd_rs2_w: got %b want 01", fwdSel2E); else pass_cnt++;
        destAddM = 7;
        #1;
        check_cnt++; if (fwdSel2E !== 2'b10) $display("FAIL fwd_rs2_m: got %b want 10", fwdSel2E); else pass_cnt++;
    endtask

    task automatic test_branch();
        do_reset();
        RegWriteE = 1; MemToRegE = 1; destAddE = 3;
        rs1D = 3; useRs1D = 1; branchTakenE = 1;
        #1;
        check_cnt++; if (ctl !== 6'b000011) $display("FAIL br_ctl: got %b want 000011", ctl); else pass_cnt++;
        tick();
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL br_state: got %0d want 0", stateOut); else pass_cnt++;
        check_cnt++; if (stallCount !== 16'd0) $display("FAIL br_stallcount: got %0d want 0", stallCount); else pass_cnt++;
    endtask

    task automatic test_mem_wait();
        do_reset();
        rs1D = 9; useRs1D = 1; destAddW = 9; RegWriteW = 1;
        tick();
        rs1D = 4; memReqM = 1; memReadyM = 0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check_cnt++; if (ctl !== 6'b111100) $display("FAIL mw_ctl_%0d: got %b want 111100", k, ctl); else pass_cnt++;
            check_cnt++; if (fwdSel1E !== 2'b01) $display("FAIL mw_hold_%0d: got %b want 01", k, fwdSel1E); else pass_cnt++;
            tick();
            check_cnt++; if (stateOut !== 2'd2) $display("FAIL mw_state_%0d: got %0d want 2", k, stateOut); else pass_cnt++;
        end
        memReadyM = 1;
        #1;
        check_cnt++; if (ctl !== 6'b000000) $display("FAIL mw_done_ctl: got %b want 000000", ctl); else pass_cnt++;
        tick();
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL mw_done_state: got %0d want 0", stateOut); else pass_cnt++;
        check_cnt++; if (stallCount !== 16'd4) $display("FAIL mw_stallcount: got %0d want 4", stallCount); else pass_cnt++;
        check_cnt++; if (memTimeout !== 1'b0) $display("FAIL mw_timeout: got %b want 0", memTimeout); else pass_cnt++;
        check_cnt++; if (fwdSel1E !== 2'b00) $display("FAIL mw_reload: got %b want 00", fwdSel1E); else pass_cnt++;
    endtask

    task automatic test_ready_branch();
        do_reset();
        memReqM = 1; memReadyM = 0;
        tick();
        memReadyM = 1; branchTakenE = 1;
        #1;
        check_cnt++; if (ctl !== 6'b000011) $display("FAIL rb_ctl: got %b want 000011", ctl); else pass_cnt++;
        tick();
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL rb_state: got %0d want 0", stateOut); else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic exp_to;
        do_reset();
        memReqM = 1; memReadyM = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            exp_to = (k >= 8);
            check_cnt++; if (memTimeout !== exp_to) $display("FAIL to_cycle_%0d: got %b want %b", k, memTimeout, exp_to); else pass_cnt++;
        end
        memReadyM = 1;
        tick();
        memReqM = 0; memReadyM = 0;
        tick();
        tick();
        check_cnt++; if (memTimeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", memTimeout); else pass_cnt++;
        check_cnt++; if (stallCount !== 16'd10) $display("FAIL to_stallcount: got %0d want 10", stallCount); else pass_cnt++;
        memReqM = 1;
        #1;
        check_cnt++; if (ctl !== 6'b111100) $display("FAIL to_still_stalls: got %b want 111100", ctl); else pass_cnt++;
        memReqM = 0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        memReqM = 1; memReadyM = 0;
        for (int k = 0; k < 9; k++) tick();
        check_cnt++; if (memTimeout !== 1'b1) $display("FAIL mr_pre_timeout: got %b want 1", memTimeout); else pass_cnt++;
        check_cnt++; if (stateOut !== 2'd2) $display("FAIL mr_pre_state: got %0d want 2", stateOut); else pass_cnt++;
        reset = 1'b0;
        #1;
        check_cnt++; if (ctl !== 6'b000000) $display("FAIL mr_ctl: got %b want 000000", ctl); else pass_cnt++;
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL mr_state: got %0d want 0", stateOut); else pass_cnt++;
        check_cnt++; if (stallCount !== 16'd0) $display("FAIL mr_stallcount: got %0d want 0", stallCount); else pass_cnt++;
        check_cnt++; if (memTimeout !== 1'b0) $display("FAIL mr_timeout: got %b want 0", memTimeout); else pass_cnt++;
        tick();
        memReqM = 0;
        reset = 1'b1;
        tick();
        check_cnt++; if (stallCount !== 16'd0) $display("FAIL mr_post_stallcount: got %0d want 0", stallCount); else pass_cnt++;
        check_cnt++; if (memTimeout !== 1'b0) $display("FAIL mr_post_timeout: got %b want 0", memTimeout); else pass_cnt++;
        check_cnt++; if (stateOut !== 2'd0) $display("FAIL mr_post_state: got %0d want 0", stateOut); else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #3;
        test_reset();
        test_load_use();
        test_forward();
        test_branch();
        test_mem_wait();
        test_ready_branch();
        test_timeout();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
